// File: rtl/csa_sub_pkg.sv
// Shared types and constants for the pipelined carry-select subtractor.
package csa_sub_pkg;

    localparam int DATA_W   = 16;
    localparam int SLICE_W  = 4;
    localparam int N_SLICES = DATA_W / SLICE_W;
    localparam int HALF_W   = DATA_W / 2;

    localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;

    // Everything the high half needs to finish the subtraction one cycle later
    typedef struct packed {
        logic [HALF_W-1:0] diff_lo;
        logic              carry;
        logic [HALF_W-1:0] a_hi;
        logic [HALF_W-1:0] b_hi;
        logic              a_msb;
        logic              b_msb;
    } s1_reg_t;

endpackage

// File: rtl/csel_sub_slice.sv
// One carry-select slice: adds a + b_n under both carry-in hypotheses and
// lets the incoming carry pick the result. b_n is the already inverted
// subtrahend, so a chain of these slices computes a + ~b + cin.
module csel_sub_slice #(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b_n,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] sum0;
    logic [SLICE_W:0] sum1;

    // Both hypotheses in parallel, then the late-arriving carry selects
    always_comb begin
        sum0 = {1'b0, a} + {1'b0, b_n};
        sum1 = {1'b0, a} + {1'b0, b_n} + {{SLICE_W{1'b0}}, 1'b1};
        if (cin) begin
            sum  = sum1[SLICE_W-1:0];
            cout = sum1[SLICE_W];
        end else begin
            sum  = sum0[SLICE_W-1:0];
            cout = sum0[SLICE_W];
        end
    end

endmodule

// File: rtl/csa_subtractor_16bit_pipe.sv
// Two-stage pipelined carry-select subtractor: diff = a - b - bin.
// Stage 1 resolves the low half and the carry into the high half; stage 2
// finishes the high half, borrow-out and signed overflow.
// Optional macro SUB_SAT_EN: saturate diff on signed overflow.
// WIDTH must match the package DATA_W (the stage-1 register is a fixed struct).
module csa_subtractor_16bit_pipe
    import csa_sub_pkg::*;
#(
    parameter int WIDTH   = DATA_W,
    parameter int SLICE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int HALF    = WIDTH / 2;
    localparam int SL_HALF = (WIDTH / SLICE_W) / 2;

`ifdef SUB_SAT_EN
    // Clamp to the representable signed extreme in the direction of a
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] x,
                                                  input logic             ov,
                                                  input logic             neg);
        if (!ov)
            return x;
        return neg ? SAT_NEG : SAT_POS;
    endfunction
`endif

    logic    s1_valid;
    logic    s1_load;
    logic    s2_load;
    s1_reg_t s1_d;
    s1_reg_t s1_q;

    // A stage may load when it is empty or its contents move on this cycle
    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // ---- stage 1: low half ----
    logic [WIDTH-1:0]   b_n;
    logic [SL_HALF:0]   c_lo;
    logic [HALF-1:0]    sum_lo;

    assign b_n     = ~b;
    assign c_lo[0] = ~bin;

    for (genvar i = 0; i < SL_HALF; i++) begin : g_lo
        csel_sub_slice #(.SLICE_W(SLICE_W)) u_slice (
            .a    (a[i*SLICE_W +: SLICE_W]),
            .b_n  (b_n[i*SLICE_W +: SLICE_W]),
            .cin  (c_lo[i]),
            .sum  (sum_lo[i*SLICE_W +: SLICE_W]),
            .cout (c_lo[i+1])
        );
    end

    // Pack the stage-1 results and the untouched high operands
    always_comb begin
        s1_d         = '0;
        s1_d.diff_lo = sum_lo;
        s1_d.carry   = c_lo[SL_HALF];
        s1_d.a_hi    = a[WIDTH-1:HALF];
        s1_d.b_hi    = b[WIDTH-1:HALF];
        s1_d.a_msb   = a[WIDTH-1];
        s1_d.b_msb   = b[WIDTH-1];
    end

    // Stage-1 occupancy; cleared by reset so in-flight beats are dropped
    always_ff @(posedge clk) begin
        if (!rst_n)
            s1_valid <= 1'b0;
        else if (s1_load)
            s1_valid <= in_valid;
    end

    // Stage-1 data register, captured only on an accepted beat
    always_ff @(posedge clk) begin
        if (s1_load && in_valid)
            s1_q <= s1_d;
    end

    // ---- stage 2: high half ----
    logic [HALF-1:0]  b_hi_n;
    logic [SL_HALF:0] c_hi;
    logic [HALF-1:0]  sum_hi;
    logic [WIDTH-1:0] diff_mod;
    logic [WIDTH-1:0] diff_res;
    logic             bout_c;
    logic             ovf_c;

    assign b_hi_n  = ~s1_q.b_hi;
    assign c_hi[0] = s1_q.carry;

    for (genvar i = 0; i < SL_HALF; i++) begin : g_hi
        csel_sub_slice #(.SLICE_W(SLICE_W)) u_slice (
            .a    (s1_q.a_hi[i*SLICE_W +: SLICE_W]),
            .b_n  (b_hi_n[i*SLICE_W +: SLICE_W]),
            .cin  (c_hi[i]),
            .sum  (sum_hi[i*SLICE_W +: SLICE_W]),
            .cout (c_hi[i+1])
        );
    end

    // Final result, borrow (inverted carry) and signed overflow
    always_comb begin
        diff_mod = {sum_hi, s1_q.diff_lo};
        bout_c   = ~c_hi[SL_HALF];
        ovf_c    = (s1_q.a_msb != s1_q.b_msb) && (sum_hi[HALF-1] != s1_q.a_msb);
`ifdef SUB_SAT_EN
        diff_res = saturate(diff_mod, ovf_c, s1_q.a_msb);
`else
        diff_res = diff_mod;
`endif
    end

    // Output register; holds while downstream stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                diff <= diff_res;
                bout <= bout_c;
                ovf  <= ovf_c;
            end
        end
    end

endmodule
